// File: rtl/mips_pkg.sv
// Shared types for the HI/LO multiply/divide unit: opcode and FSM state enums,
// plus the quotient fill pattern used on divide-by-zero.
package mips_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd8,
        OP_MADDU = 4'd9,
        OP_MSUB  = 4'd10,
        OP_MSUBU = 4'd11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } muldiv_state_e;

    // Sliced down to DATA_W by the users; wide enough for the largest legal width.
    localparam logic [63:0] DIV_ZERO_QUOT_FILL = {64{1'b1}};

endpackage

// File: rtl/muldiv_divider.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// then a fixup cycle where signs, divide-by-zero and the results are presented.
module muldiv_divider
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              done_o,
    output logic [DATA_W-1:0] quot_o,
    output logic [DATA_W-1:0] rem_o
);

    localparam int CW = $clog2(DATA_W + 1);

    logic              active_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W-1:0] dividend_q;
    logic              negQuot_q;
    logic              negRem_q;
    logic              divZero_q;

    logic              dividendNeg;
    logic              divisorNeg;
    logic [DATA_W-1:0] dividendAbs;
    logic [DATA_W-1:0] divisorAbs;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;

    assign dividendNeg = signed_i & dividend_i[DATA_W-1];
    assign divisorNeg  = signed_i & divisor_i[DATA_W-1];
    assign dividendAbs = dividendNeg ? -dividend_i : dividend_i;
    assign divisorAbs  = divisorNeg ? -divisor_i : divisor_i;

    // Partial remainder always stays below the divisor, so bit DATA_W of trial is the borrow.
    assign shifted = {rem_q, quo_q[DATA_W-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q   <= 1'b0;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            dividend_q <= '0;
            negQuot_q  <= 1'b0;
            negRem_q   <= 1'b0;
            divZero_q  <= 1'b0;
        end else if (start_i) begin
            active_q   <= 1'b1;
            cnt_q      <= CW'(DATA_W);
            rem_q      <= '0;
            quo_q      <= dividendAbs;
            dvs_q      <= divisorAbs;
            dividend_q <= dividend_i;
            negQuot_q  <= dividendNeg ^ divisorNeg;
            negRem_q   <= dividendNeg;
            divZero_q  <= (divisor_i == '0);
        end else if (active_q) begin
            if (cnt_q != '0) begin
                if (!trial[DATA_W]) begin
                    rem_q <= trial[DATA_W-1:0];
                    quo_q <= {quo_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_q <= shifted[DATA_W-1:0];
                    quo_q <= {quo_q[DATA_W-2:0], 1'b0};
                end
                cnt_q <= cnt_q - 1'b1;
            end else begin
                active_q <= 1'b0;
            end
        end
    end

    assign done_o = active_q && (cnt_q == '0);
    assign quot_o = divZero_q ? DIV_ZERO_QUOT_FILL[DATA_W-1:0] : (negQuot_q ? -quo_q : quo_q);
    assign rem_o  = divZero_q ? dividend_q : (negRem_q ? -rem_q : rem_q);

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Define HILO_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulation into {HI,LO}.
module hilo_muldiv_unit
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [3:0]        op_code,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              op_ready,
    output logic              busy,
    input  logic              rd_req,
    output logic              stall_req,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic              done
);

    localparam logic [2:0] MUL_CNT_LOAD = 3'(MUL_LAT - 1);

    muldiv_state_e     state_q;
    logic [2:0]        cnt_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] mulA_q;
    logic [DATA_W-1:0] mulB_q;
    logic              mulSigned_q;
    logic              done_q;
`ifdef HILO_MADD_EN
    logic              accAdd_q;
    logic              accSub_q;
    logic              decAcc;
    logic              decSub;
`endif

    logic              decMul;
    logic              decMulSigned;
    logic              decDiv;
    logic              decDivSigned;
    logic              decMthi;
    logic              decMtlo;
    logic              accept;

    logic [2*DATA_W-1:0] extA;
    logic [2*DATA_W-1:0] extB;
    logic [2*DATA_W-1:0] prodComb;
    logic [2*DATA_W-1:0] mulRes;
    logic [2*DATA_W-1:0] mulCommit;

    logic              divDone;
    logic [DATA_W-1:0] divQuot;
    logic [DATA_W-1:0] divRem;

    always_comb begin
        decMul       = 1'b0;
        decMulSigned = 1'b0;
        decDiv       = 1'b0;
        decDivSigned = 1'b0;
        decMthi      = 1'b0;
        decMtlo      = 1'b0;
`ifdef HILO_MADD_EN
        decAcc       = 1'b0;
        decSub       = 1'b0;
`endif
        case (op_code)
            OP_MULT:  begin decMul = 1'b1; decMulSigned = 1'b1; end
            OP_MULTU: decMul = 1'b1;
            OP_DIV:   begin decDiv = 1'b1; decDivSigned = 1'b1; end
            OP_DIVU:  decDiv = 1'b1;
            OP_MTHI:  decMthi = 1'b1;
            OP_MTLO:  decMtlo = 1'b1;
`ifdef HILO_MADD_EN
            OP_MADD:  begin decMul = 1'b1; decMulSigned = 1'b1; decAcc = 1'b1; end
            OP_MADDU: begin decMul = 1'b1; decAcc = 1'b1; end
            OP_MSUB:  begin decMul = 1'b1; decMulSigned = 1'b1; decAcc = 1'b1; decSub = 1'b1; end
            OP_MSUBU: begin decMul = 1'b1; decAcc = 1'b1; decSub = 1'b1; end
`endif
            default:  ;
        endcase
    end

    assign accept = op_valid && (state_q == IDLE);

    // Sign-extending to double width makes a single modulo-2^(2W) multiply serve both MULT and MULTU.
    assign extA     = {{DATA_W{mulSigned_q & mulA_q[DATA_W-1]}}, mulA_q};
    assign extB     = {{DATA_W{mulSigned_q & mulB_q[DATA_W-1]}}, mulB_q};
    assign prodComb = extA * extB;

    generate
        if (MUL_LAT == 1) begin : g_mulComb
            assign mulRes = prodComb;
        end else begin : g_mulPipe
            logic [2*DATA_W-1:0] pipe_q [MUL_LAT-1];
            always_ff @(posedge clk) begin
                pipe_q[0] <= prodComb;
                for (int i = 1; i < MUL_LAT - 1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign mulRes = pipe_q[MUL_LAT-2];
        end
    endgenerate

    always_comb begin
        mulCommit = mulRes;
`ifdef HILO_MADD_EN
        if (accAdd_q) begin
            mulCommit = {hi_q, lo_q} + mulRes;
        end else if (accSub_q) begin
            mulCommit = {hi_q, lo_q} - mulRes;
        end
`endif
    end

    muldiv_divider #(
        .DATA_W(DATA_W)
    ) u_divider (
        .clk        (clk),
        .reset      (reset),
        .start_i    (accept && decDiv),
        .signed_i   (decDivSigned),
        .dividend_i (op_a),
        .divisor_i  (op_b),
        .done_o     (divDone),
        .quot_o     (divQuot),
        .rem_o      (divRem)
    );

    // HI/LO only ever change on MTHI/MTLO accept or on a final commit, never mid-operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            mulA_q      <= '0;
            mulB_q      <= '0;
            mulSigned_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef HILO_MADD_EN
            accAdd_q    <= 1'b0;
            accSub_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (decMul) begin
                            state_q     <= MUL;
                            mulA_q      <= op_a;
                            mulB_q      <= op_b;
                            mulSigned_q <= decMulSigned;
`ifdef HILO_MADD_EN
                            accAdd_q    <= decAcc && !decSub;
                            accSub_q    <= decAcc && decSub;
                            cnt_q       <= decAcc ? MUL_CNT_LOAD + 3'd1 : MUL_CNT_LOAD;
`else
                            cnt_q       <= MUL_CNT_LOAD;
`endif
                        end else if (decDiv) begin
                            state_q <= DIV;
                        end else if (decMthi) begin
                            hi_q <= op_a;
                        end else if (decMtlo) begin
                            lo_q <= op_a;
                        end
                    end
                end
                MUL: begin
                    if (cnt_q == '0) begin
                        {hi_q, lo_q} <= mulCommit;
                        done_q       <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                DIV: begin
                    if (divDone) begin
                        hi_q    <= divRem;
                        lo_q    <= divQuot;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign op_ready  = (state_q == IDLE);
    assign busy      = (state_q == MUL) || (state_q == DIV);
    assign stall_req = rd_req && busy;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign done      = done_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit (DATA_W=32, MUL_LAT=2);
// expectations for opcodes 8..11 follow whether HILO_MADD_EN is defined.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [3:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        rd_req;
    logic        op_ready;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    hilo_muldiv_unit #(
        .DATA_W  (32),
        .MUL_LAT (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_code   (op_code),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_ready  (op_ready),
        .busy      (busy),
        .rd_req    (rd_req),
        .stall_req (stall_req),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Presents one op for a single cycle; returns 1 time unit after the accept edge.
    task automatic issueOp(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = code;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_code  = 4'd0;
        op_a     = '0;
        op_b     = '0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        op_valid = 1'b0;
        op_code  = 4'd0;
        op_a     = '0;
        op_b     = '0;
        rd_req   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        vectors++; if (hi_out !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_hi: got %h expected %h", hi_out, 32'h0); end
        vectors++; if (lo_out !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_lo: got %h expected %h", lo_out, 32'h0); end
        vectors++; if (op_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 1", op_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_mult;
        int cycles;
        issueOp(4'd1, 32'hFFFFFFFE, 32'd3);
        vectors++; if (busy !== 1'b1 || op_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL mult_busy: got busy=%b ready=%b expected busy=1 ready=0", busy, op_ready); end
        waitDone(cycles);
        vectors++; if (cycles !== 2) begin miscompares++; $display("[TB] FAIL mult_latency: got %0d expected 2", cycles); end
        vectors++; if (hi_out !== 32'hFFFFFFFF) begin miscompares++; $display("[TB] FAIL mult_hi: got %h expected %h", hi_out, 32'hFFFFFFFF); end
        vectors++; if (lo_out !== 32'hFFFFFFFA) begin miscompares++; $display("[TB] FAIL mult_lo: got %h expected %h", lo_out, 32'hFFFFFFFA); end
        vectors++; if (op_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mult_ready_with_done: got %b expected 1", op_ready); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL mult_done_pulse: got %b expected 0", done); end

        issueOp(4'd2, 32'hFFFFFFFE, 32'd3);
        waitDone(cycles);
        vectors++; if (cycles !== 2) begin miscompares++; $display("[TB] FAIL multu_latency: got %0d expected 2", cycles); end
        vectors++; if (hi_out !== 32'h00000002) begin miscompares++; $display("[TB] FAIL multu_hi: got %h expected %h", hi_out, 32'h2); end
        vectors++; if (lo_out !== 32'hFFFFFFFA) begin miscompares++; $display("[TB] FAIL multu_lo: got %h expected %h", lo_out, 32'hFFFFFFFA); end
    endtask

    task automatic test_div;
        int cycles;
        issueOp(4'd3, 32'hFFFFFFF9, 32'd2);
        @(posedge clk); #1;
        vectors++; if (lo_out !== 32'hFFFFFFFA) begin miscompares++; $display("[TB] FAIL div_lo_held: got %h expected %h", lo_out, 32'hFFFFFFFA); end
        waitDone(cycles);
        vectors++; if (cycles !== 32) begin miscompares++; $display("[TB] FAIL div_latency: got %0d expected 32 more", cycles); end
        vectors++; if (lo_out !== 32'hFFFFFFFD) begin miscompares++; $display("[TB] FAIL div_lo: got %h expected %h", lo_out, 32'hFFFFFFFD); end
        vectors++; if (hi_out !== 32'hFFFFFFFF) begin miscompares++; $display("[TB] FAIL div_hi: got %h expected %h", hi_out, 32'hFFFFFFFF); end

        issueOp(4'd4, 32'd100, 32'd7);
        waitDone(cycles);
        vectors++; if (cycles !== 33) begin miscompares++; $display("[TB] FAIL divu_latency: got %0d expected 33", cycles); end
        vectors++; if (lo_out !== 32'd14) begin miscompares++; $display("[TB] FAIL divu_lo: got %h expected %h", lo_out, 32'd14); end
        vectors++; if (hi_out !== 32'd2) begin miscompares++; $display("[TB] FAIL divu_hi: got %h expected %h", hi_out, 32'd2); end
    endtask

    task automatic test_div_special;
        int cycles;
        issueOp(4'd3, 32'h00001234, 32'd0);
        waitDone(cycles);
        vectors++; if (cycles !== 33) begin miscompares++; $display("[TB] FAIL divzero_latency: got %0d expected 33", cycles); end
        vectors++; if (lo_out !== 32'hFFFFFFFF) begin miscompares++; $display("[TB] FAIL divzero_lo: got %h expected %h", lo_out, 32'hFFFFFFFF); end
        vectors++; if (hi_out !== 32'h00001234) begin miscompares++; $display("[TB] FAIL divzero_hi: got %h expected %h", hi_out, 32'h1234); end

        issueOp(4'd3, 32'h80000000, 32'hFFFFFFFF);
        waitDone(cycles);
        vectors++; if (lo_out !== 32'h80000000) begin miscompares++; $display("[TB] FAIL divovf_lo: got %h expected %h", lo_out, 32'h80000000); end
        vectors++; if (hi_out !== 32'h0) begin miscompares++; $display("[TB] FAIL divovf_hi: got %h expected %h", hi_out, 32'h0); end
    endtask

    task automatic test_stall_and_move;
        int cycles;
        issueOp(4'd1, 32'd5, 32'd6);
        rd_req   = 1'b1;
        op_valid = 1'b1;
        op_code  = 4'd6;
        op_a     = 32'h00005555;
        #1;
        vectors++; if (stall_req !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_busy0: got %b expected 1", stall_req); end
        @(posedge clk); #1;
        vectors++; if (stall_req !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_busy1: got %b expected 1", stall_req); end
        op_valid = 1'b0;
        op_code  = 4'd0;
        op_a     = '0;
        waitDone(cycles);
        vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_release: got %b expected 0", stall_req); end
        vectors++; if (lo_out !== 32'd30) begin miscompares++; $display("[TB] FAIL mtlo_ignored_lo: got %h expected %h", lo_out, 32'd30); end
        rd_req = 1'b0;

        issueOp(4'd6, 32'h0000A5A5, 32'd0);
        vectors++; if (lo_out !== 32'h0000A5A5) begin miscompares++; $display("[TB] FAIL mtlo_lo: got %h expected %h", lo_out, 32'hA5A5); end
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL mtlo_no_busy: got busy=%b done=%b expected 0 0", busy, done); end
        issueOp(4'd5, 32'h00005A5A, 32'd0);
        vectors++; if (hi_out !== 32'h00005A5A) begin miscompares++; $display("[TB] FAIL mthi_hi: got %h expected %h", hi_out, 32'h5A5A); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL mthi_no_done: got %b expected 0", done); end
    endtask

    task automatic test_back_to_back;
        int cycles;
        issueOp(4'd1, 32'd7, 32'd8);
        waitDone(cycles);
        vectors++; if (lo_out !== 32'd56) begin miscompares++; $display("[TB] FAIL b2b_first_lo: got %h expected %h", lo_out, 32'd56); end
        issueOp(4'd2, 32'h00010000, 32'h00010000);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_accept: got %b expected 1", busy); end
        waitDone(cycles);
        vectors++; if (cycles !== 2) begin miscompares++; $display("[TB] FAIL b2b_latency: got %0d expected 2", cycles); end
        vectors++; if (hi_out !== 32'd1 || lo_out !== 32'd0) begin miscompares++; $display("[TB] FAIL b2b_hilo: got %h_%h expected 00000001_00000000", hi_out, lo_out); end
    endtask

    task automatic test_madd;
        int cycles;
        int doneSeen;
        issueOp(4'd5, 32'd0, 32'd0);
        issueOp(4'd6, 32'd5, 32'd0);
`ifdef HILO_MADD_EN
        issueOp(4'd8, 32'd3, 32'd4);
        waitDone(cycles);
        vectors++; if (cycles !== 3) begin miscompares++; $display("[TB] FAIL madd_latency: got %0d expected 3", cycles); end
        vectors++; if (lo_out !== 32'd17 || hi_out !== 32'd0) begin miscompares++; $display("[TB] FAIL madd_hilo: got %h_%h expected 00000000_00000011", hi_out, lo_out); end
        issueOp(4'd10, 32'd10, 32'd1);
        waitDone(cycles);
        vectors++; if (lo_out !== 32'd7 || hi_out !== 32'd0) begin miscompares++; $display("[TB] FAIL msub_hilo: got %h_%h expected 00000000_00000007", hi_out, lo_out); end
`else
        issueOp(4'd8, 32'd3, 32'd4);
        vectors++; if (op_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL madd_nop_idle: got ready=%b busy=%b expected 1 0", op_ready, busy); end
        issueOp(4'd10, 32'd10, 32'd1);
        doneSeen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) doneSeen++;
            @(posedge clk); #1;
        end
        vectors++; if (doneSeen !== 0) begin miscompares++; $display("[TB] FAIL madd_nop_done: got %0d pulses expected 0", doneSeen); end
        vectors++; if (lo_out !== 32'd5 || hi_out !== 32'd0) begin miscompares++; $display("[TB] FAIL madd_nop_hilo: got %h_%h expected 00000000_00000005", hi_out, lo_out); end
`endif
    endtask

    task automatic test_reset_mid_div;
        int doneSeen;
        issueOp(4'd5, 32'h00005A5A, 32'd0);
        issueOp(4'd4, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++; if (hi_out !== 32'h0 || lo_out !== 32'h0) begin miscompares++; $display("[TB] FAIL abort_hilo: got %h_%h expected 00000000_00000000", hi_out, lo_out); end
        vectors++; if (op_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_idle: got ready=%b busy=%b expected 1 0", op_ready, busy); end
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) doneSeen++;
            @(posedge clk); #1;
        end
        vectors++; if (doneSeen !== 0) begin miscompares++; $display("[TB] FAIL abort_done: got %0d pulses expected 0", doneSeen); end
        vectors++; if (lo_out !== 32'h0) begin miscompares++; $display("[TB] FAIL abort_lo_after: got %h expected %h", lo_out, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_special();
        test_stall_and_move();
        test_back_to_back();
        test_madd();
        test_reset_mid_div();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
